// File: rtl/icache_fill_pkg.sv
// Shared icache geometry and refill-engine state encoding.
// Imported by the icache and by the refill engine.
package icache_fill_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned INST_WIDTH  = 32;
    localparam int unsigned INDEX_WIDTH = 4;
    localparam int unsigned TAG_WIDTH   = 24;

    // PC bit positions of the icache index and tag fields.
    localparam int unsigned INDEX_LSB = 4;
    localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_WIDTH;

    // The read phase spends one extra cycle past the last address to capture the final byte.
    localparam logic [2:0] LAST_BEAT = 3'(INST_WIDTH / 8);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitGnt = 2'd1,
        StRead    = 2'd2,
        StDone    = 2'd3
    } fill_state_e;

endpackage

// File: rtl/icache_fill.sv
// Instruction-miss refill engine: fetches four bytes from the byte-wide RAM port
// and hands the little-endian word to the icache as a single update pulse.
module icache_fill
    import icache_fill_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic                   miss_en_in,
    input  logic [ADDR_WIDTH-1:0]  miss_pc_in,
    output logic                   mem_req_out,
    input  logic                   mem_gnt_in,
    output logic [ADDR_WIDTH-1:0]  mem_a_out,
    output logic                   mem_wr_out,
    input  logic [7:0]             mem_din_in,
    output logic                   update_out,
    output logic [INST_WIDTH-1:0]  inst_out,
    output logic [INDEX_WIDTH-1:0] idx_out,
    output logic [TAG_WIDTH-1:0]   tag_out,
    output logic                   busy_out
);

    fill_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [INST_WIDTH-1:0]  buf_q, buf_d;
    logic [INST_WIDTH-1:0]  inst_q, inst_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;

    logic [1:0]             addr_off;
    logic [1:0]             byte_sel;

    // Address stays on the last byte while that byte is still in flight.
    assign addr_off = (cnt_q >= 3'd3) ? 2'd3 : cnt_q[1:0];
    // Data returned in beat k belongs to byte k-1; beat 4 wraps to byte 3.
    assign byte_sel = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        inst_d  = inst_q;
        idx_d   = idx_q;
        tag_d   = tag_q;

        unique case (state_q)
            StIdle: begin
                if (miss_en_in && !flush_in) begin
                    base_d  = miss_pc_in;
                    state_d = StWaitGnt;
                end
            end

            StWaitGnt: begin
                if (flush_in) begin
                    state_d = StIdle;
                end else if (mem_gnt_in) begin
                    cnt_d   = '0;
                    state_d = StRead;
                end
            end

            StRead: begin
                if (flush_in) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d[{byte_sel, 3'b000} +: 8] = mem_din_in;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        inst_d  = buf_d;
                        idx_d   = base_q[INDEX_LSB +: INDEX_WIDTH];
                        tag_d   = base_q[TAG_LSB +: TAG_WIDTH];
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            StDone: begin
                // Flush is ignored here: the word is valid for its PC regardless.
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            base_q  <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            inst_q  <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            inst_q  <= inst_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        mem_req_out = (state_q == StWaitGnt) || (state_q == StRead);
        mem_a_out   = (state_q == StRead) ? (base_q + ADDR_WIDTH'(addr_off)) : '0;
        mem_wr_out  = 1'b0;
        update_out  = (state_q == StDone);
        busy_out    = (state_q != StIdle);
        inst_out    = inst_q;
        idx_out     = idx_q;
        tag_out     = tag_q;
    end

endmodule

// File: tb/tb_icache_fill.sv
// Randomized bench for icache_fill against a byte-RAM reference model.
module tb_icache_fill;
    import icache_fill_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n_in, rdy_in, flush_in, miss_en_in, mem_gnt_in;
    logic [31:0] miss_pc_in;
    logic [7:0]  mem_din_in = 8'h00;
    logic        mem_req_out, mem_wr_out, update_out, busy_out;
    logic [31:0] mem_a_out, inst_out;
    logic [3:0]  idx_out;
    logic [23:0] tag_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int upd_count = 0;
    int upd_cyc = 0;
    logic [31:0] upd_inst;
    logic [3:0]  upd_idx;
    logic [23:0] upd_tag;

    logic [7:0] ram [logic [31:0]];

    always #5 clk = ~clk;

    icache_fill dut (
        .clk         (clk),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .miss_en_in  (miss_en_in),
        .miss_pc_in  (miss_pc_in),
        .mem_req_out (mem_req_out),
        .mem_gnt_in  (mem_gnt_in),
        .mem_a_out   (mem_a_out),
        .mem_wr_out  (mem_wr_out),
        .mem_din_in  (mem_din_in),
        .update_out  (update_out),
        .inst_out    (inst_out),
        .idx_out     (idx_out),
        .tag_out     (tag_out),
        .busy_out    (busy_out)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5a;
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] pc);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ram_rd(pc + 32'(k));
        return w;
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] pc, input int i);
        return pc + 32'((i > 3) ? 3 : i);
    endfunction

    // RAM returns the byte at the previous cycle's address; frozen with the rest of the system.
    always @(posedge clk) if (rdy_in) mem_din_in <= ram_rd(mem_a_out);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (update_out === 1'b1) begin
            upd_count++;
            upd_cyc  = cyc;
            upd_inst = inst_out;
            upd_idx  = idx_out;
            upd_tag  = tag_out;
        end
    end

    // Drives one refill from IDLE; starts and ends on a falling edge, ends in the DONE cycle.
    task automatic run_fill(input logic [31:0] pc, input int gnt_delay, input int stall_k,
                            input int stall_len, input bit noise,
                            output logic [4:0][31:0] obs, output int hold_bad,
                            output int miss_cyc);
        logic [31:0] first_a;
        hold_bad   = 0;
        obs        = '0;
        miss_en_in = 1'b1;
        miss_pc_in = pc;
        @(negedge clk);
        miss_en_in = 1'b0;
        miss_cyc   = cyc;
        first_a    = mem_a_out;
        for (int d = 0; d < gnt_delay; d++) begin
            if (mem_req_out !== 1'b1 || mem_a_out !== first_a || update_out !== 1'b0) hold_bad++;
            if (noise) begin
                miss_pc_in = $urandom;
                miss_en_in = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        if (mem_req_out !== 1'b1) hold_bad++;
        mem_gnt_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs[i] = mem_a_out;
            if (mem_req_out !== 1'b1 || update_out !== 1'b0) hold_bad++;
            if (noise) begin
                miss_pc_in = $urandom;
                miss_en_in = 1'($urandom_range(0, 1));
            end
            if (i == stall_k) begin
                rdy_in = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    if (mem_a_out !== obs[i] || mem_req_out !== 1'b1 || update_out !== 1'b0)
                        hold_bad++;
                end
                rdy_in = 1'b1;
            end
        end
        miss_en_in = 1'b0;
        @(negedge clk);
        mem_gnt_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; miss_en_in = 1'b0;
        mem_gnt_in = 1'b0; miss_pc_in = 32'hdead_beef;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req_out, mem_a_out, update_out, inst_out, idx_out, tag_out, mem_wr_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b a=%h upd=%b inst=%h idx=%h tag=%h wr=%b exp all 0",
                     mem_req_out, mem_a_out, update_out, inst_out, idx_out, tag_out, mem_wr_out);
        end
        checks++;
        if (busy_out !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy_out);
        end
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || mem_req_out !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset got busy=%b req=%b exp 0 0", busy_out, mem_req_out);
        end
    endtask

    task automatic test_basic();
        logic [4:0][31:0] obs;
        int hold_bad, miss_cyc, n0;
        ram[32'h1234] = 8'h13; ram[32'h1235] = 8'h05; ram[32'h1236] = 8'h10; ram[32'h1237] = 8'h00;
        n0 = upd_count;
        run_fill(32'h1234, 0, -1, 0, 1'b0, obs, hold_bad, miss_cyc);
        checks++;
        if (mem_wr_out !== 1'b0) begin failures++; $display("FAIL basic_wr got=%b exp=0", mem_wr_out); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== model_addr(32'h1234, i)) begin
                failures++;
                $display("FAIL basic_addr[%0d] got=%h exp=%h", i, obs[i], model_addr(32'h1234, i));
            end
        end
        checks++;
        if (upd_count - n0 != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", upd_count - n0); end
        checks++;
        if (upd_inst !== 32'h0010_0513) begin failures++; $display("FAIL basic_inst got=%h exp=00100513", upd_inst); end
        checks++;
        if (upd_idx !== 4'h3 || upd_tag !== 24'h000012) begin
            failures++; $display("FAIL basic_idx_tag got=%h/%h exp=3/000012", upd_idx, upd_tag);
        end
        checks++;
        if (upd_cyc - miss_cyc != 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", upd_cyc - miss_cyc); end
        checks++;
        if (update_out !== 1'b0 || busy_out !== 1'b0 || hold_bad != 0) begin
            failures++; $display("FAIL basic_after got upd=%b busy=%b hold_bad=%0d exp 0 0 0", update_out, busy_out, hold_bad);
        end
        checks++;
        if (inst_out !== 32'h0010_0513) begin failures++; $display("FAIL basic_inst_hold got=%h exp=00100513", inst_out); end
    endtask

    task automatic test_delayed_grant();
        logic [4:0][31:0] obs;
        int hold_bad, miss_cyc, n0;
        logic [31:0] pc;
        pc = 32'h0003_a5c8;
        n0 = upd_count;
        run_fill(pc, 5, -1, 0, 1'b0, obs, hold_bad, miss_cyc);
        @(negedge clk);
        checks++;
        if (hold_bad != 0) begin failures++; $display("FAIL delay_wait_hold got=%0d bad cycles exp=0", hold_bad); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== model_addr(pc, i)) begin
                failures++; $display("FAIL delay_addr[%0d] got=%h exp=%h", i, obs[i], model_addr(pc, i));
            end
        end
        checks++;
        if (upd_count - n0 != 1 || upd_inst !== model_inst(pc)) begin
            failures++; $display("FAIL delay_update got n=%0d inst=%h exp n=1 inst=%h", upd_count - n0, upd_inst, model_inst(pc));
        end
        checks++;
        if (upd_cyc - miss_cyc != 11) begin failures++; $display("FAIL delay_latency got=%0d exp=11", upd_cyc - miss_cyc); end
    endtask

    task automatic test_flush();
        logic [4:0][31:0] obs;
        int hold_bad, miss_cyc, n0;
        n0 = upd_count;
        miss_en_in = 1'b1; miss_pc_in = 32'h0000_4000;
        @(negedge clk);
        miss_en_in = 1'b0; mem_gnt_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_a_out !== 32'h0000_4001) begin failures++; $display("FAIL flush_pre_addr got=%h exp=00004001", mem_a_out); end
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0; mem_gnt_in = 1'b0;
        checks++;
        if (mem_req_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++; $display("FAIL flush_abort got req=%b busy=%b exp 0 0", mem_req_out, busy_out);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (upd_count != n0) begin failures++; $display("FAIL flush_no_update got=%0d exp=0", upd_count - n0); end
        run_fill(32'h0000_0080, 1, -1, 0, 1'b0, obs, hold_bad, miss_cyc);
        @(negedge clk);
        checks++;
        if (upd_count - n0 != 1 || upd_inst !== model_inst(32'h80) || upd_idx !== 4'h8 || upd_tag !== 24'h0) begin
            failures++;
            $display("FAIL flush_refill got n=%0d inst=%h idx=%h tag=%h exp n=1 inst=%h idx=8 tag=0",
                     upd_count - n0, upd_inst, upd_idx, upd_tag, model_inst(32'h80));
        end
    endtask

    task automatic test_flush_miss_idle();
        flush_in = 1'b1; miss_en_in = 1'b1; miss_pc_in = 32'h0000_9000;
        @(negedge clk);
        flush_in = 1'b0; miss_en_in = 1'b0;
        checks++;
        if (mem_req_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++; $display("FAIL flush_miss_idle got req=%b busy=%b exp 0 0", mem_req_out, busy_out);
        end
    endtask

    task automatic test_rdy_stall();
        logic [4:0][31:0] obs;
        int hold_bad, miss_cyc, n0;
        logic [31:0] pc;
        pc = 32'h0000_5670;
        n0 = upd_count;
        run_fill(pc, 0, 2, 3, 1'b0, obs, hold_bad, miss_cyc);
        @(negedge clk);
        checks++;
        if (hold_bad != 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", hold_bad); end
        checks++;
        if (obs[2] !== pc + 32'd2 || obs[4] !== pc + 32'd3) begin
            failures++; $display("FAIL stall_addr got=%h/%h exp=%h/%h", obs[2], obs[4], pc + 32'd2, pc + 32'd3);
        end
        checks++;
        if (upd_count - n0 != 1 || upd_inst !== model_inst(pc)) begin
            failures++; $display("FAIL stall_inst got n=%0d inst=%h exp n=1 inst=%h", upd_count - n0, upd_inst, model_inst(pc));
        end
        checks++;
        if (upd_cyc - miss_cyc != 9) begin failures++; $display("FAIL stall_latency got=%0d exp=9", upd_cyc - miss_cyc); end
        // A miss seen only while frozen must not start a refill.
        rdy_in = 1'b0; miss_en_in = 1'b1; miss_pc_in = 32'h0000_7770;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || idx_out !== 4'h7 || inst_out !== model_inst(pc)) begin
            failures++; $display("FAIL stall_idle_freeze got busy=%b idx=%h inst=%h exp 0 7 %h", busy_out, idx_out, inst_out, model_inst(pc));
        end
        miss_en_in = 1'b0; rdy_in = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b0) begin failures++; $display("FAIL stall_idle_resume got busy=%b exp=0", busy_out); end
    endtask

    task automatic test_wrap();
        logic [4:0][31:0] obs;
        int hold_bad, miss_cyc;
        logic [31:0] exp_a [5];
        exp_a = '{32'hffff_fffe, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
        run_fill(32'hffff_fffe, 0, -1, 0, 1'b0, obs, hold_bad, miss_cyc);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, obs[i], exp_a[i]); end
        end
        checks++;
        if (upd_tag !== 24'hffffff || upd_idx !== 4'hf || upd_inst !== model_inst(32'hffff_fffe)) begin
            failures++; $display("FAIL wrap_update got tag=%h idx=%h inst=%h exp ffffff f %h",
                                 upd_tag, upd_idx, upd_inst, model_inst(32'hffff_fffe));
        end
    endtask

    task automatic test_async_reset();
        int n0;
        n0 = upd_count;
        miss_en_in = 1'b1; miss_pc_in = 32'h2000_0040;
        @(negedge clk);
        miss_en_in = 1'b0; mem_gnt_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b1) begin failures++; $display("FAIL areset_pre got req=%b exp=1", mem_req_out); end
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({mem_req_out, mem_a_out, update_out, inst_out, idx_out, tag_out, busy_out, mem_wr_out} !== '0) begin
            failures++;
            $display("FAIL areset_outputs got req=%b a=%h upd=%b inst=%h idx=%h tag=%h busy=%b exp all 0",
                     mem_req_out, mem_a_out, update_out, inst_out, idx_out, tag_out, busy_out);
        end
        @(negedge clk);
        mem_gnt_in = 1'b0; rst_n_in = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (upd_count != n0 || busy_out !== 1'b0 || mem_req_out !== 1'b0) begin
            failures++; $display("FAIL areset_quiet got n=%0d busy=%b req=%b exp 0 0 0", upd_count - n0, busy_out, mem_req_out);
        end
    endtask

    task automatic test_random();
        logic [4:0][31:0] obs;
        int hold_bad, miss_cyc, n0, d, sk, sl, lat;
        logic [31:0] pc;
        for (int it = 0; it < 24; it++) begin
            pc = $urandom;
            for (int k = 0; k < 4; k++) ram[pc + 32'(k)] = 8'($urandom_range(0, 255));
            d  = $urandom_range(0, 3);
            sk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
            sl = $urandom_range(1, 3);
            lat = 6 + d + ((sk >= 0) ? sl : 0);
            n0 = upd_count;
            run_fill(pc, d, sk, sl, 1'b1, obs, hold_bad, miss_cyc);
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs[i] !== model_addr(pc, i)) begin
                    failures++; $display("FAIL rand%0d_addr[%0d] got=%h exp=%h", it, i, obs[i], model_addr(pc, i));
                end
            end
            checks++;
            if (upd_count - n0 != 1 || upd_inst !== model_inst(pc)) begin
                failures++; $display("FAIL rand%0d_inst got n=%0d inst=%h exp n=1 inst=%h", it, upd_count - n0, upd_inst, model_inst(pc));
            end
            checks++;
            if (upd_idx !== pc[7:4] || upd_tag !== pc[31:8]) begin
                failures++; $display("FAIL rand%0d_idx_tag got=%h/%h exp=%h/%h", it, upd_idx, upd_tag, pc[7:4], pc[31:8]);
            end
            checks++;
            if (upd_cyc - miss_cyc != lat || hold_bad != 0) begin
                failures++; $display("FAIL rand%0d_timing got lat=%0d hold_bad=%0d exp lat=%0d hold_bad=0", it, upd_cyc - miss_cyc, hold_bad, lat);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_grant();
        test_flush();
        test_flush_miss_idle();
        test_rdy_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
